pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush controller for the dual-issue pipeline.
- Turns per-stage stall requests into the 5-bit stall vector consumed by id_of and the downstream pipeline registers.
- Sequences exception and ERET flushes: flush, flush_cause and the redirect PC to fetch.
- Holds an exception that arrives while the commit stage is stalled, and releases it once the stall clears.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect PC for exceptions
WDT_LIMIT, 1023, consecutive-stall-cycle threshold (optional feature only)

Ports:
clk  input  1  clock
resetn  input  1  synchronous reset, active low
stallreq_i  input  5  stall request from stage k (0=ID/OF, 1=OF/EX, 2=EX/MEM, 3=MEM/WB, 4=WB)
exc_valid_i  input  1  commit stage reports exception or ERET this cycle
exc_is_eret_i  input  1  1=ERET, 0=exception; qualified by exc_valid_i
epc_i  input  32  return address for ERET
stall  output  5  stall vector; bit k=Stop freezes stage k
flush  output  1  pipeline flush pulse
flush_cause  output  1  0=exception, 1=ERET; valid with flush
new_pc_o  output  32  redirect target; valid with flush
wdt_o  output  1  stall watchdog tripped (optional feature; tied 0 otherwise)

Behaviour:
- Reset (resetn low at posedge): synchronous.
  - state=RUN; all pending registers cleared.
  - flush=0, flush_cause=0, new_pc_o=0, wdt_o=0.
  - stall=0 from the first cycle after reset.
  - Reset mid-PEND or mid-FLUSH discards the pending event; no flush is issued.
- Stall vector (combinational from stallreq_i and state):
  - h = highest index with stallreq_i[h]=1; stall[h:0]=all ones, bits above h=0.
  - No request: stall=0.
  - In state FLUSH: stall=0 regardless of requests.
  - Gives the bubble-insert rule "stall[k]=Stop and stall[k+1]=NoStop".
- FSM states RUN, PEND, FLUSH:
  - RUN:
    - exc_valid_i=1 and stall[3]=0: latch cause and target, go to FLUSH.
    - exc_valid_i=1 and stall[3]=1: latch cause and target, go to PEND.
    - Otherwise stay in RUN.
  - PEND:
    - Latched event held.
    - Further exc_valid_i is ignored; the pending event is older and wins.
    - When stall[3]=0, go to FLUSH.
  - FLUSH:
    - For exactly one cycle: flush=1, flush_cause=latched cause, new_pc_o=latched target.
    - Next cycle: back to RUN with flush=0.
    - exc_valid_i during FLUSH is ignored (the instruction is being flushed).
- Latency:
  - exc_valid_i sampled at edge N with stall[3]=0 gives flush high during cycle N+1. Latency is 1 cycle; all flush-side outputs are registered.
  - From PEND: flush rises the cycle after the first cycle with stall[3]=0.
- Target select:
  - exc_is_eret_i=1: new_pc_o=epc_i, flush_cause=1.
  - Otherwise: new_pc_o=EXC_VECTOR, flush_cause=0.
- new_pc_o and flush_cause hold their last values while flush=0.
- Back-to-back: exception on the cycle right after FLUSH (state RUN) is accepted normally. Minimum flush spacing is 2 cycles.
- Simultaneous exception and stallreq_i[4..3] in RUN: goes to PEND. Stall requests on stages 0..2 alone do not delay the flush.

Optional Feature:
Macro PIPE_CTRL_STALL_WDT_EN.
- Defined:
  - A 10-bit saturating counter increments on each cycle with stall!=0 and clears on any cycle with stall=0 or flush=1.
  - When the counter reaches WDT_LIMIT, wdt_o becomes 1 and stays 1 (sticky) until reset.
  - The counter does not wrap.
- Undefined: no counter is generated and wdt_o is tied to 0.

Test Plan:
- Reset, then stallreq_i=5'b00100 -> stall=5'b00111. stallreq_i=5'b00001 -> stall=5'b00001. stallreq_i=0 -> stall=0.
- exc_valid_i=1, exc_is_eret_i=0, stallreq_i=0 at edge N -> cycle N+1 has flush=1, flush_cause=0, new_pc_o=32'hBFC00380 and stall=0. Cycle N+2 has flush=0.
- ERET with epc_i=32'h80001234 while stallreq_i[3]=1 for 3 cycles -> PEND. A second exception injected during PEND is ignored. Flush pulse comes the cycle after stallreq_i[3] drops, with new_pc_o=32'h80001234 and flush_cause=1.
- Exception at N and a new exception at N+1 (the FLUSH cycle) -> only one flush. Exception at N+2 -> second flush at N+3.
- resetn low while in PEND -> no flush afterwards; all outputs 0.
- PIPE_CTRL_STALL_WDT_EN defined, WDT_LIMIT=8, stallreq_i=5'b10000 held -> wdt_o rises after the 8th consecutive stall cycle and stays 1 after stall clears. Undefined build -> wdt_o stays 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush controller for the dual-issue pipeline (optional stall watchdog: PIPE_CTRL_STALL_WDT_EN)
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned WDT_LIMIT  = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  stallreq_i,
  input  logic        exc_valid_i,
  input  logic        exc_is_eret_i,
  input  logic [31:0] epc_i,
  output logic [4:0]  stall,
  output logic        flush,
  output logic        flush_cause,
  output logic [31:0] new_pc_o,
  output logic        wdt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      state, next_state;
  logic        pend_cause;
  logic [31:0] pend_pc;
  logic        load_pend;
  logic        next_cause;
  logic [31:0] next_pc;
  logic [4:0]  therm;

  // Thermometer stall vector: every stage at or below the highest requester freezes
  always_comb begin
    therm = {stallreq_i[4], |stallreq_i[4:3], |stallreq_i[4:2], |stallreq_i[4:1], |stallreq_i[4:0]};
    stall = (state == ST_FLUSH) ? 5'b00000 : therm;
  end

  // Next state and the event to latch; a held event always beats a newer one
  always_comb begin
    next_state = state;
    load_pend  = 1'b0;
    next_cause = pend_cause;
    next_pc    = pend_pc;
    case (state)
      ST_RUN: begin
        if (exc_valid_i) begin
          load_pend  = 1'b1;
          next_cause = exc_is_eret_i;
          next_pc    = exc_is_eret_i ? epc_i : EXC_VECTOR;
          next_state = stall[3] ? ST_PEND : ST_FLUSH;
        end
      end
      ST_PEND: begin
        if (!stall[3]) next_state = ST_FLUSH;
      end
      ST_FLUSH: next_state = ST_RUN;
      default:  next_state = ST_RUN;
    endcase
  end

  // State, pending event and registered flush-side outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_RUN;
      pend_cause  <= 1'b0;
      pend_pc     <= 32'h0;
      flush       <= 1'b0;
      flush_cause <= 1'b0;
      new_pc_o    <= 32'h0;
    end else begin
      state <= next_state;
      if (load_pend) begin
        pend_cause <= next_cause;
        pend_pc    <= next_pc;
      end
      flush <= (next_state == ST_FLUSH);
      if (next_state == ST_FLUSH) begin
        flush_cause <= next_cause;
        new_pc_o    <= next_pc;
      end
    end
  end

`ifdef PIPE_CTRL_STALL_WDT_EN
  logic [9:0] wdt_cnt, wdt_cnt_next;

  // Saturating count of consecutive stalled cycles
  always_comb begin
    if ((stall == 5'b00000) || flush) wdt_cnt_next = 10'd0;
    else if (wdt_cnt != 10'h3FF)      wdt_cnt_next = wdt_cnt + 10'd1;
    else                              wdt_cnt_next = wdt_cnt;
  end

  // Counter register and sticky trip flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wdt_cnt <= 10'd0;
      wdt_o   <= 1'b0;
    end else begin
      wdt_cnt <= wdt_cnt_next;
      if (wdt_cnt_next == 10'(WDT_LIMIT)) wdt_o <= 1'b1;
    end
  end
`else
  logic unused_wdt_limit;
  assign unused_wdt_limit = (WDT_LIMIT != 0);
  assign wdt_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk;
  logic        resetn;
  logic [4:0]  stallreq_i;
  logic        exc_valid_i;
  logic        exc_is_eret_i;
  logic [31:0] epc_i;
  logic [4:0]  stall;
  logic        flush;
  logic        flush_cause;
  logic [31:0] new_pc_o;
  logic        wdt_o;

  int tests  = 0;
  int failed = 0;
  logic exp_wdt;

  pipe_ctrl #(
    .EXC_VECTOR (32'hBFC00380),
    .WDT_LIMIT  (8)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stallreq_i    (stallreq_i),
    .exc_valid_i   (exc_valid_i),
    .exc_is_eret_i (exc_is_eret_i),
    .epc_i         (epc_i),
    .stall         (stall),
    .flush         (flush),
    .flush_cause   (flush_cause),
    .new_pc_o      (new_pc_o),
    .wdt_o         (wdt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; stallreq_i = 5'b0; exc_valid_i = 1'b0; exc_is_eret_i = 1'b0; epc_i = 32'h0;
    tick(); tick();
    resetn = 1'b1; #1;
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_cause", 32'(flush_cause), 32'd0);
    check("rst_pc", new_pc_o, 32'h0);
    check("rst_wdt", 32'(wdt_o), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    stallreq_i = 5'b00100; #1; check("stall_00100", 32'(stall), 32'h07);
    stallreq_i = 5'b00001; #1; check("stall_00001", 32'(stall), 32'h01);
    stallreq_i = 5'b00000; #1; check("stall_none", 32'(stall), 32'h00);
    stallreq_i = 5'b01010; #1; check("stall_01010", 32'(stall), 32'h0F);
    stallreq_i = 5'b10001; #1; check("stall_10001", 32'(stall), 32'h1F);
    stallreq_i = 5'b00000;

    // exception with no stall: flush one cycle later, stall forced off in FLUSH
    exc_valid_i = 1'b1; exc_is_eret_i = 1'b0; epc_i = 32'h12345678;
    tick();
    exc_valid_i = 1'b0; stallreq_i = 5'b00100; #1;
    check("exc_flush", 32'(flush), 32'd1);
    check("exc_cause", 32'(flush_cause), 32'd0);
    check("exc_pc", new_pc_o, 32'hBFC00380);
    check("exc_stall_forced", 32'(stall), 32'd0);
    tick();
    check("exc_flush_end", 32'(flush), 32'd0);
    check("exc_stall_back", 32'(stall), 32'h07);
    check("exc_pc_hold", new_pc_o, 32'hBFC00380);
    stallreq_i = 5'b00000;

    // ERET while MEM/WB stalled for 3 cycles; a newer exception in PEND is dropped
    exc_valid_i = 1'b1; exc_is_eret_i = 1'b1; epc_i = 32'h80001234; stallreq_i = 5'b01000;
    tick();
    check("pend_no_flush0", 32'(flush), 32'd0);
    exc_valid_i = 1'b1; exc_is_eret_i = 1'b0; epc_i = 32'hDEADBEEF;
    tick();
    check("pend_no_flush1", 32'(flush), 32'd0);
    exc_valid_i = 1'b0;
    tick();
    check("pend_no_flush2", 32'(flush), 32'd0);
    stallreq_i = 5'b00000;
    tick();
    check("pend_flush", 32'(flush), 32'd1);
    check("pend_cause", 32'(flush_cause), 32'd1);
    check("pend_pc", new_pc_o, 32'h80001234);
    tick();
    check("pend_flush_end", 32'(flush), 32'd0);
    check("pend_cause_hold", 32'(flush_cause), 32'd1);
    check("pend_pc_hold", new_pc_o, 32'h80001234);
    tick();
    check("pend_no_second", 32'(flush), 32'd0);

    // back-to-back: exception during FLUSH ignored, next one two cycles later accepted
    exc_valid_i = 1'b1; exc_is_eret_i = 1'b0;
    tick();
    check("b2b_flush1", 32'(flush), 32'd1);
    check("b2b_pc1", new_pc_o, 32'hBFC00380);
    exc_valid_i = 1'b1; exc_is_eret_i = 1'b1; epc_i = 32'h0000AAAA;
    tick();
    check("b2b_ignored", 32'(flush), 32'd0);
    exc_valid_i = 1'b1; exc_is_eret_i = 1'b1; epc_i = 32'h80005678;
    tick();
    exc_valid_i = 1'b0;
    check("b2b_flush2", 32'(flush), 32'd1);
    check("b2b_cause2", 32'(flush_cause), 32'd1);
    check("b2b_pc2", new_pc_o, 32'h80005678);
    tick();
    check("b2b_end", 32'(flush), 32'd0);

    // stage 0..2 stalls alone do not delay the flush
    exc_valid_i = 1'b1; exc_is_eret_i = 1'b0; stallreq_i = 5'b00111;
    tick();
    exc_valid_i = 1'b0; stallreq_i = 5'b00000;
    check("low_stall_flush", 32'(flush), 32'd1);
    tick();

    // reset while PEND discards the event
    exc_valid_i = 1'b1; exc_is_eret_i = 1'b1; epc_i = 32'h80009999; stallreq_i = 5'b10000;
    tick();
    exc_valid_i = 1'b0;
    check("rp_pend", 32'(flush), 32'd0);
    resetn = 1'b0; stallreq_i = 5'b00000;
    tick();
    resetn = 1'b1; #1;
    check("rp_flush", 32'(flush), 32'd0);
    check("rp_cause", 32'(flush_cause), 32'd0);
    check("rp_pc", new_pc_o, 32'h0);
    check("rp_stall", 32'(stall), 32'd0);
    check("rp_wdt", 32'(wdt_o), 32'd0);
    tick();
    check("rp_no_flush1", 32'(flush), 32'd0);
    tick();
    check("rp_no_flush2", 32'(flush), 32'd0);

    // stall watchdog: trips after 8 consecutive stalled cycles, then sticky
    stallreq_i = 5'b10000;
    for (int i = 1; i <= 10; i++) begin
      tick();
`ifdef PIPE_CTRL_STALL_WDT_EN
      exp_wdt = (i >= 8);
`else
      exp_wdt = 1'b0;
`endif
      check($sformatf("wdt_cyc%0d", i), 32'(wdt_o), 32'(exp_wdt));
    end
    stallreq_i = 5'b00000;
    tick(); tick();
    check("wdt_sticky", 32'(wdt_o), 32'(exp_wdt));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
